// File: rtl/out_port_seg7_driver_if.sv
// Port-value / display bundle between an out_port register and the seven-segment driver.
interface out_port_seg7_driver_if;
   logic [31:0] value;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic        busy;
   logic        ovf;

   modport master (
      output value,
      input  hex0, hex1, hex2, hex3, hex4, hex5, busy, ovf
   );

   modport slave (
      input  value,
      output hex0, hex1, hex2, hex3, hex4, hex5, busy, ovf
   );
endinterface

// File: rtl/out_port_seg7_driver.sv
// Converts a 32-bit port value to six decimal digits by sequential double-dabble and drives
// six active-low seven-segment displays; outputs only change when a conversion completes.
module out_port_seg7_driver #(
   parameter bit LZ_BLANK = 1'b1
) (
   input logic                   io_clk,
   input logic                   clr,
   out_port_seg7_driver_if.slave bus
);

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state;
   logic [31:0] shadow;
   logic        valid;
   logic [19:0] shift;
   logic [23:0] bcd;
   logic [4:0]  cnt;
   logic        ovf_pend;

   logic [23:0] bcd_adj;
   logic [6:0]  seg [6];
   logic        lead_nz;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction applied to every BCD nibble before each shift.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 6; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Digit k is blank when it and everything above it are zero; hex0 is always shown.
   always_comb begin
      lead_nz = 1'b0;
      for (int k = 5; k >= 0; k--) begin
         lead_nz = lead_nz | (bcd[4*k +: 4] != 4'd0);
         if (ovf_pend) begin
            seg[k] = SEG_DASH;
         end else if (LZ_BLANK && (k != 0) && !lead_nz) begin
            seg[k] = SEG_BLANK;
         end else begin
            seg[k] = seg7(bcd[4*k +: 4]);
         end
      end
   end

   always_ff @(posedge io_clk) begin
      if (clr) begin
         state    <= StIdle;
         valid    <= 1'b0;
         shadow   <= '0;
         shift    <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         bus.busy <= 1'b0;
         bus.ovf  <= 1'b0;
         bus.hex0 <= SEG_BLANK;
         bus.hex1 <= SEG_BLANK;
         bus.hex2 <= SEG_BLANK;
         bus.hex3 <= SEG_BLANK;
         bus.hex4 <= SEG_BLANK;
         bus.hex5 <= SEG_BLANK;
      end else begin
         unique case (state)
            StIdle: begin
               if (!valid || (bus.value != shadow)) begin
                  shadow   <= bus.value;
                  ovf_pend <= (bus.value > 32'd999999);
                  shift    <= bus.value[19:0];
                  bcd      <= '0;
                  cnt      <= '0;
                  state    <= StShift;
                  bus.busy <= 1'b1;
               end
            end
            StShift: begin
               {bcd, shift} <= {bcd_adj[22:0], shift, 1'b0};
               cnt          <= cnt + 5'd1;
               if (cnt == 5'd19) begin
                  state <= StDone;
               end
            end
            StDone: begin
               bus.hex0 <= seg[0];
               bus.hex1 <= seg[1];
               bus.hex2 <= seg[2];
               bus.hex3 <= seg[3];
               bus.hex4 <= seg[4];
               bus.hex5 <= seg[5];
               bus.ovf  <= ovf_pend;
               valid    <= 1'b1;
               state    <= StIdle;
               bus.busy <= 1'b0;
            end
            default: begin
               state    <= StIdle;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out_port_seg7_driver.sv
// Randomised and directed bench for out_port_seg7_driver; a decimal-arithmetic model predicts
// every displayed digit, busy and ovf, and a per-cycle compare checks both blanking variants.
module tb_out_port_seg7_driver;

   logic        io_clk;
   logic        clr;
   logic [31:0] value;
   logic        chk_en;

   int n_tests;
   int n_fail;

   out_port_seg7_driver_if ua ();
   out_port_seg7_driver_if ub ();

   assign ua.value = value;
   assign ub.value = value;

   out_port_seg7_driver #(.LZ_BLANK(1'b1)) u_dut_lz (
      .io_clk (io_clk),
      .clr    (clr),
      .bus    (ua)
   );

   out_port_seg7_driver #(.LZ_BLANK(1'b0)) u_dut_full (
      .io_clk (io_clk),
      .clr    (clr),
      .bus    (ub)
   );

   logic [41:0] hex_a, hex_b;
   assign hex_a = {ua.hex5, ua.hex4, ua.hex3, ua.hex2, ua.hex1, ua.hex0};
   assign hex_b = {ub.hex5, ub.hex4, ub.hex3, ub.hex2, ub.hex1, ub.hex0};

   initial io_clk = 1'b0;
   always #5 io_clk = ~io_clk;

   function automatic logic [6:0] seg_of(input int unsigned d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected display {hex5..hex0} for a value, using plain decimal arithmetic.
   function automatic logic [41:0] exp_disp(input logic [31:0] v, input bit lz);
      logic [41:0] r;
      int unsigned p;
      int unsigned d;
      r = '1;
      p = 1;
      for (int k = 0; k < 6; k++) begin
         d = (v / p) % 10;
         if (v > 32'd999999) r[7*k +: 7] = 7'b0111111;
         else if (lz && (k > 0) && (v < p)) r[7*k +: 7] = 7'b1111111;
         else r[7*k +: 7] = seg_of(d);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: a conversion is just "busy for 21 edges, then show the captured value".
   int          m_left;
   logic        m_valid;
   logic [31:0] m_shadow;
   logic        m_ovf;
   logic [41:0] m_disp_a, m_disp_b;

   always @(posedge io_clk) begin
      if (clr) begin
         m_left   = 0;
         m_valid  = 1'b0;
         m_ovf    = 1'b0;
         m_disp_a = '1;
         m_disp_b = '1;
      end else if (m_left > 1) begin
         m_left = m_left - 1;
      end else if (m_left == 1) begin
         m_left   = 0;
         m_disp_a = exp_disp(m_shadow, 1'b1);
         m_disp_b = exp_disp(m_shadow, 1'b0);
         m_ovf    = (m_shadow > 32'd999999);
         m_valid  = 1'b1;
      end else if (!m_valid || (value != m_shadow)) begin
         m_shadow = value;
         m_left   = 21;
      end
   end

   always @(negedge io_clk) begin
      if (chk_en) begin
         chk("busy_a", 42'(ua.busy), 42'(m_left != 0));
         chk("busy_b", 42'(ub.busy), 42'(m_left != 0));
         chk("ovf_a", 42'(ua.ovf), 42'(m_ovf));
         chk("ovf_b", 42'(ub.ovf), 42'(m_ovf));
         chk("hex_a", hex_a, m_disp_a);
         chk("hex_b", hex_b, m_disp_b);
      end
   end

   // Apply a new value and count the busy cycles of the conversion it starts.
   task automatic conv(input logic [31:0] v, output int cyc);
      @(posedge io_clk);
      #1 value = v;
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge io_clk);
         if (ua.busy) cyc++;
         else if (cyc > 0) break;
      end
   endtask

   int          cyc;
   logic [41:0] snap;
   int unsigned r;
   logic [31:0] v;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      chk_en  = 1'b0;
      clr     = 1'b1;
      value   = 32'd0;
      repeat (3) @(posedge io_clk);
      #1 chk_en = 1'b1;
      @(negedge io_clk);
      chk("reset_hex", hex_a, {6{7'b1111111}});
      chk("reset_busy", 42'(ua.busy), 42'd0);
      chk("reset_ovf", 42'(ua.ovf), 42'd0);

      @(posedge io_clk);
      #1 clr = 1'b0;
      value  = 32'd123456;
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge io_clk);
         if (ua.busy) cyc++;
         else if (cyc > 0) break;
      end
      chk("busy_len_123456", 42'(cyc), 42'd21);
      chk("hex_123456", hex_a, {7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010});
      chk("ovf_123456", 42'(ua.ovf), 42'd0);

      conv(32'd42, cyc);
      chk("busy_len_42", 42'(cyc), 42'd21);
      chk("hex_42_lz", hex_a, {{4{7'b1111111}}, 7'b0011001, 7'b0100100});
      chk("hex_42_full", hex_b, {{4{7'b1000000}}, 7'b0011001, 7'b0100100});

      conv(32'd0, cyc);
      chk("hex_0_lz", hex_a, {{5{7'b1111111}}, 7'b1000000});

      conv(32'd1000000, cyc);
      chk("hex_1000000", hex_a, {6{7'b0111111}});
      chk("ovf_1000000", 42'(ua.ovf), 42'd1);
      conv(32'hFFFF_FFFF, cyc);
      chk("hex_ffffffff", hex_b, {6{7'b0111111}});
      chk("ovf_ffffffff", 42'(ua.ovf), 42'd1);
      conv(32'd999999, cyc);
      chk("hex_999999", hex_a, {6{7'b0010000}});
      chk("ovf_999999", 42'(ua.ovf), 42'd0);

      // Change the value partway through a conversion.
      @(posedge io_clk);
      #1 value = 32'd555;
      repeat (11) @(posedge io_clk);
      #1 value = 32'd777;
      for (int i = 0; i < 100; i++) begin
         @(negedge io_clk);
         if (!ua.busy) break;
      end
      chk("hex_555", hex_a, {{3{7'b1111111}}, {3{7'b0010010}}});
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge io_clk);
         if (ua.busy) cyc++;
         else if (cyc > 0) break;
      end
      chk("busy_len_777", 42'(cyc), 42'd21);
      chk("hex_777", hex_a, {{3{7'b1111111}}, {3{7'b1111000}}});

      // One-edge reset in the middle of a conversion.
      @(posedge io_clk);
      #1 value = 32'd98765;
      repeat (5) @(posedge io_clk);
      #1 clr = 1'b1;
      @(posedge io_clk);
      @(negedge io_clk);
      chk("clr_busy", 42'(ua.busy), 42'd0);
      chk("clr_hex", hex_a, {6{7'b1111111}});
      clr = 1'b0;
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge io_clk);
         if (ua.busy) cyc++;
         else if (cyc > 0) break;
      end
      chk("busy_len_98765", 42'(cyc), 42'd21);
      chk("hex_98765", hex_a, {7'b1111111, 7'b0010000, 7'b0000000,
                               7'b1111000, 7'b0000010, 7'b0010010});

      // Constant value while idle.
      snap = hex_a;
      for (int i = 0; i < 100; i++) begin
         @(negedge io_clk);
         chk("hold_busy", 42'(ua.busy), 42'd0);
      end
      chk("hold_hex", hex_a, snap);

      // Random values arriving at random times, with occasional resets.
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4) v = 32'($urandom_range(0, 999999));
         else if (r < 6) v = 32'($urandom_range(0, 99));
         else if (r < 8) v = $urandom;
         else if (r == 8) v = value;
         else v = ($urandom_range(0, 1) == 0) ? 32'd999999 : 32'd1000000;
         repeat ($urandom_range(1, 30)) @(posedge io_clk);
         #1 value = v;
         if ($urandom_range(0, 19) == 0) begin
            @(posedge io_clk);
            #1 clr = 1'b1;
            @(posedge io_clk);
            #1 clr = 1'b0;
         end
      end
      repeat (60) @(posedge io_clk);
      @(negedge io_clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/out_port_seg7_driver.md
Name: out_port_seg7_driver

Overview:
- Downstream consumer of one memory-mapped output port register (e.g. out_port0, written at 80h). Converts the 32-bit port value to six decimal digits and drives six active-low seven-segment displays.
- Conversion is sequential (shift-and-add-3 double-dabble, one bit per cycle), so no wide combinational divider is needed.
- Display outputs are registered and change only when a conversion completes, so they never flicker.

Parameters:
- LZ_BLANK, 1, when 1 blank leading-zero digits above the most significant nonzero digit (hex0 always shown); when 0 show all six digits.

Ports:
- io_clk  input  1  system I/O clock; all state updates on its rising edge.
- clr  input  1  synchronous, active-high reset.
- value  input  32  port value to display (connect to an out_port output).
- hex0..hex5  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 is the least significant digit.
- busy  output  1  high while a conversion is in progress.
- ovf  output  1  high when the last converted value exceeded 999999.

Behaviour:
- Reset (clr=1 at an edge): state=IDLE, valid=0, busy=0, ovf=0, hex0..hex5=7'h7F (blank). Reset aborts any conversion in progress.
- Registers: shadow[31:0] (last converted value), valid, shift[19:0], bcd[23:0], cnt[4:0], ovf_pend.
- IDLE:
  - If valid=0 or value!=shadow at an edge: shadow<=value, ovf_pend<=(value>999999), shift<=value[19:0], bcd<=0, cnt<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - Every 4-bit BCD nibble >=5 gets +3.
  - Then shift {bcd,shift} left by 1.
  - cnt<=cnt+1.
  - After the 20th shift (cnt==19 at the edge), go to DONE.
- DONE, one edge:
  - Write hex0..hex5 from bcd, write ovf<=ovf_pend, valid<=1, go to IDLE.
  - If ovf_pend=1, all six digits show dash 7'b0111111 regardless of LZ_BLANK.
- busy = (state!=IDLE), registered from state.
- Latency: value sampled at edge E0 → busy high after E0 → outputs and ovf updated, busy low after E0+21. Sustained changes are handled at one conversion per 22 cycles.
- Input change during SHIFT/DONE: ignored. On return to IDLE the mismatch against shadow triggers a new conversion. The intermediate value is never partially displayed.
- value unchanged while idle: no conversion and no output change.
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111
- Leading-zero blanking (LZ_BLANK=1): digit k (k>=1) is blank if digits k..5 are all zero. A value of 0 shows hex0='0' and all others blank.
- Value bits [31:20] take part only in the overflow test; the BCD path converts value[19:0].

Test Plan:
- Reset, then value=123456 held → busy=1 for 21 cycles; then hex5..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010; ovf=0.
- LZ_BLANK=1, value=42 → hex1=0011001, hex0=0100100, hex2..hex5=1111111. Then value=0 → hex0=1000000, others blank. With LZ_BLANK=0, value=42 → hex5..hex2 all 1000000.
- value=1000000, then 32'hFFFFFFFF → all digits 0111111 and ovf=1. Then value=999999 → all digits 0010000 and ovf=0.
- value=555 converting; change to 777 at cycle 10 of SHIFT → outputs show 555 at completion, then a second busy period of 21 cycles, then 777. 555 is never skipped and no mixed digits appear.
- Mid-SHIFT assert clr for 1 cycle with value=98765 → outputs blank and busy=0 immediately after the edge. After release, the conversion restarts and 98765 appears 21 cycles later.
- value held constant for 100 cycles after DONE → busy stays 0 and outputs do not change.
